// File: rtl/rx_frame_sequencer.sv
// ---------------------------------------------------------------------------
// rx_frame_sequencer
//
// Receive-side frame control FSM sitting behind the XGMII control-character
// decoder. It strobes the address and length/type capture points and
// qualifies data words toward the RX FIFO. It counts frame bytes and emits
// one status word per frame.
//
// Ports
//   rxclk, reset          receive clock; synchronous active-high reset
//   get_sfd               start+SFD detect (registered by the decoder)
//   get_terminator        terminate-character detect
//   terminator_location   valid data bytes (0-7) in the terminator word
//   get_error_code        error-character flag, one cycle after get_terminator
//   tagged_frame          VLAN tag present (raises the length limit by 4)
//   crc_ok                FCS result, valid the cycle after get_terminator
//   start_da, start_lt    one-cycle capture strobes (1st / 2nd RX cycle)
//   receiving             FSM is in RX or DROP
//   data_valid            current decoder word belongs to the frame
//   data_last, last_bytes final frame word and its valid byte count
//   status_valid          one-cycle pulse; the status fields below are valid
//   frame_good, frame_len, err_code, too_long, too_short, crc_err, aborted
//                         per-frame status, held until the next status_valid
// ---------------------------------------------------------------------------
module rx_frame_sequencer #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        rxclk,
  input  logic        reset,
  input  logic        get_sfd,
  input  logic        get_terminator,
  input  logic [2:0]  terminator_location,
  input  logic        get_error_code,
  input  logic        tagged_frame,
  input  logic        crc_ok,
  output logic        start_da,
  output logic        start_lt,
  output logic        receiving,
  output logic        data_valid,
  output logic        data_last,
  output logic [2:0]  last_bytes,
  output logic        status_valid,
  output logic        frame_good,
  output logic [15:0] frame_len,
  output logic        err_code,
  output logic        too_long,
  output logic        too_short,
  output logic        crc_err,
  output logic        aborted
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RX    = 2'd1,
    DROP  = 2'd2,
    CHECK = 2'd3
  } state_t;

  state_t      state;
  logic [12:0] word_cnt;
  logic [15:0] len_q;        // closed frame length, published at status time
  logic        too_long_q;
  logic        sfd_pending;  // SFD that arrived together with a terminator

  logic [15:0] byte_cnt;
  logic [16:0] term_sum;
  logic [15:0] term_len;
  logic [15:0] limit;
  logic        over_limit;
  logic [12:0] word_cnt_next;
  logic        in_frame;
  logic        start_frame;

  assign in_frame      = (state == RX) || (state == DROP);
  assign byte_cnt      = {word_cnt, 3'b000};
  assign term_sum      = {1'b0, byte_cnt} + 17'(terminator_location);
  assign term_len      = term_sum[16] ? 16'hFFFF : term_sum[15:0];
  assign limit         = 16'(MAX_LEN) + (tagged_frame ? 16'd4 : 16'd0);
  assign over_limit    = byte_cnt > limit;
  assign word_cnt_next = (&word_cnt) ? word_cnt : word_cnt + 13'd1;

  // A new frame opens from IDLE, from CHECK (back-to-back or a deferred SFD),
  // or by aborting a frame that never saw its terminator.
  assign start_frame = ((state == IDLE)  && get_sfd)
                    || (in_frame && get_sfd && !get_terminator)
                    || ((state == CHECK) && (get_sfd || sfd_pending));

  // The data qualifiers must line up with the decoder word of the same
  // cycle, so they decode the state register and the live terminator flag.
  assign receiving  = in_frame;
  assign data_valid = (state == RX);
  assign data_last  = (state == RX) && get_terminator;
  assign last_bytes = data_last ? terminator_location : 3'd0;

  always_ff @(posedge rxclk) begin
    if (reset) begin
      state        <= IDLE;
      word_cnt     <= '0;
      len_q        <= '0;
      too_long_q   <= 1'b0;
      sfd_pending  <= 1'b0;
      start_da     <= 1'b0;
      start_lt     <= 1'b0;
      status_valid <= 1'b0;
      frame_good   <= 1'b0;
      frame_len    <= '0;
      err_code     <= 1'b0;
      too_long     <= 1'b0;
      too_short    <= 1'b0;
      crc_err      <= 1'b0;
      aborted      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments everywhere here, so every branch reads
      // the pre-edge values of state, word_cnt and the flags.
      start_da     <= 1'b0;
      status_valid <= 1'b0;
      start_lt     <= start_da && (state == RX) && !get_terminator && !get_sfd;

      unique case (state)
        IDLE: ;
        RX, DROP: begin
          if (get_terminator) begin
            len_q       <= term_len;
            too_long_q  <= too_long_q || ((state == RX) && over_limit);
            sfd_pending <= get_sfd;
            state       <= CHECK;
          end else if (get_sfd) begin
            // Abort: publish the truncated frame immediately.
            status_valid <= 1'b1;
            frame_good   <= 1'b0;
            frame_len    <= byte_cnt;
            err_code     <= 1'b0;
            too_long     <= too_long_q;
            too_short    <= 1'b0;
            crc_err      <= 1'b0;
            aborted      <= 1'b1;
          end else begin
            word_cnt <= word_cnt_next;
            if ((state == RX) && over_limit) begin
              too_long_q <= 1'b1;
              state      <= DROP;
            end
          end
        end
        CHECK: begin
          status_valid <= 1'b1;
          frame_len    <= len_q;
          err_code     <= get_error_code;
          crc_err      <= ~crc_ok;
          too_long     <= too_long_q;
          too_short    <= len_q < 16'(MIN_LEN);
          aborted      <= 1'b0;
          frame_good   <= ~(get_error_code | too_long_q
                            | (len_q < 16'(MIN_LEN)) | ~crc_ok);
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // NOTE: this block comes after the case on purpose; its assignments to
      // state/word_cnt/flags take precedence over the ones made above.
      if (start_frame) begin
        state       <= RX;
        start_da    <= 1'b1;
        word_cnt    <= '0;
        too_long_q  <= 1'b0;
        sfd_pending <= 1'b0;
      end
    end
  end

endmodule
